instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 168 ++++++++++++++++
 tb/tb_instr_encoder.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_encoder: registers an instruction field bundle, packs it into a     |
// | RV32 I/S/B/U/J word with range checking, queues it in a 2-entry FIFO.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic        err_seen
);

  localparam logic [2:0]  c_FMT_I = 3'd0;
  localparam logic [2:0]  c_FMT_S = 3'd1;
  localparam logic [2:0]  c_FMT_B = 3'd2;
  localparam logic [2:0]  c_FMT_U = 3'd3;
  localparam logic [2:0]  c_FMT_J = 3'd4;
  localparam logic [31:0] c_NOP   = 32'h0000_0013;

  // Input stage (S1)
  logic        s1_valid_q, s1_valid_d;
  logic [2:0]  s1_fmt_q;
  logic [6:0]  s1_opcode_q;
  logic [2:0]  s1_funct3_q;
  logic [4:0]  s1_rd_q, s1_rs1_q, s1_rs2_q;
  logic [31:0] s1_imm_q;

  // Output FIFO
  logic [31:0] fifo_instr_q [2];
  logic [31:0] fifo_addr_q  [2];
  logic [1:0]  fifo_err_q;
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] addr_q;
  logic        err_seen_q;

  logic        pop, wr_ok, push, accept;
  logic [31:0] enc_instr;
  logic        enc_err;
  logic        fits12, fits13, fits21;
  logic        unused_funct7;

  // No supported format carries funct7; it is accepted and discarded.
  assign unused_funct7 = ^in_funct7;

  assign pop      = (cnt_q != 2'd0) && out_ready;
  assign wr_ok    = (cnt_q != 2'd2) || pop;
  assign push     = s1_valid_q && wr_ok;
  assign in_ready = !s1_valid_q || wr_ok;
  assign accept   = in_valid && in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (accept) begin
      s1_valid_d = 1'b1;
    end else if (push) begin
      s1_valid_d = 1'b0;
    end
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  // Sign-extension checks: upper bits must all equal the top kept bit.
  assign fits12 = (&s1_imm_q[31:11]) | ~(|s1_imm_q[31:11]);
  assign fits13 = (&s1_imm_q[31:12]) | ~(|s1_imm_q[31:12]);
  assign fits21 = (&s1_imm_q[31:20]) | ~(|s1_imm_q[31:20]);

  always_comb begin
    enc_instr = c_NOP;
    enc_err   = 1'b1;
    case (s1_fmt_q)
      c_FMT_I: begin
        enc_instr = {s1_imm_q[11:0], s1_rs1_q, s1_funct3_q, s1_rd_q, s1_opcode_q};
        enc_err   = !fits12;
      end
      c_FMT_S: begin
        enc_instr = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                     s1_imm_q[4:0], s1_opcode_q};
        enc_err   = !fits12;
      end
      c_FMT_B: begin
        enc_instr = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, s1_funct3_q,
                     s1_imm_q[4:1], s1_imm_q[11], s1_opcode_q};
        enc_err   = !fits13 || s1_imm_q[0];
      end
      c_FMT_U: begin
        enc_instr = {s1_imm_q[31:12], s1_rd_q, s1_opcode_q};
        enc_err   = (s1_imm_q[11:0] != 12'd0);
      end
      c_FMT_J: begin
        enc_instr = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12],
                     s1_rd_q, s1_opcode_q};
        enc_err   = !fits21 || s1_imm_q[0];
      end
      default: begin
        enc_instr = c_NOP;
        enc_err   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      cnt_q      <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      addr_q     <= BASE_ADDR;
      err_seen_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      cnt_q      <= cnt_d;
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
        addr_q   <= addr_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        if (fifo_err_q[rd_ptr_q]) begin
          err_seen_q <= 1'b1;
        end
      end
    end
  end

  // Datapath storage needs no reset; validity is tracked by the control state.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_fmt_q    <= in_fmt;
      s1_opcode_q <= in_opcode;
      s1_funct3_q <= in_funct3;
      s1_rd_q     <= in_rd;
      s1_rs1_q    <= in_rs1;
      s1_rs2_q    <= in_rs2;
      s1_imm_q    <= in_imm;
    end
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= enc_instr;
      fifo_addr_q[wr_ptr_q]  <= addr_q;
      fifo_err_q[wr_ptr_q]   <= enc_err;
    end
  end

  // When empty, the address output shows the next address to be assigned.
  assign out_valid = (cnt_q != 2'd0);
  assign out_instr = out_valid ? fifo_instr_q[rd_ptr_q] : 32'd0;
  assign out_addr  = out_valid ? fifo_addr_q[rd_ptr_q] : addr_q;
  assign out_err   = out_valid & fifo_err_q[rd_ptr_q];
  assign err_seen  = err_seen_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_instr_encoder: directed and random checks of instr_encoder against a  |
// | reference encoder and transaction-level occupancy model.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_instr_encoder;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } bundle_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } word_t;

  localparam logic [31:0] BASE_B = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  bundle_t     b_drv;
  logic        a_in_ready, a_out_valid, a_out_err, a_err_seen;
  logic [31:0] a_out_instr, a_out_addr;
  logic        b_in_ready, b_out_valid, b_out_err, b_err_seen;
  logic [31:0] b_out_instr, b_out_addr;

  always #5 clk = ~clk;

  instr_encoder #(.BASE_ADDR(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_fmt(b_drv.fmt), .in_opcode(b_drv.opc), .in_funct3(b_drv.f3),
    .in_funct7(b_drv.f7), .in_rd(b_drv.rd), .in_rs1(b_drv.rs1), .in_rs2(b_drv.rs2),
    .in_imm(b_drv.imm), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_instr(a_out_instr), .out_addr(a_out_addr), .out_err(a_out_err),
    .err_seen(a_err_seen)
  );

  instr_encoder #(.BASE_ADDR(BASE_B)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_fmt(b_drv.fmt), .in_opcode(b_drv.opc), .in_funct3(b_drv.f3),
    .in_funct7(b_drv.f7), .in_rd(b_drv.rd), .in_rs1(b_drv.rs1), .in_rs2(b_drv.rs2),
    .in_imm(b_drv.imm), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_instr(b_out_instr), .out_addr(b_out_addr), .out_err(b_out_err),
    .err_seen(b_err_seen)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  int          n_fail = 0;
  logic        m_s1;
  int          m_fifo;
  bundle_t     q[$];
  int          n_pop;
  logic        m_err_seen;
  word_t       pops[$];
  logic [31:0] pop_addr_b[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference encoder: fields placed by arithmetic shifts/masks, ranges as integers.
  function automatic logic [32:0] ref_enc(input bundle_t b);
    logic [31:0] im, w;
    int          s;
    logic        e;
    im = b.imm;
    s  = $signed(b.imm);
    w  = 32'd0;
    e  = 1'b0;
    case (b.fmt)
      3'd0: begin
        w = ((im & 32'hFFF) << 20) | (32'(b.rs1) << 15) | (32'(b.f3) << 12)
          | (32'(b.rd) << 7) | 32'(b.opc);
        e = (s < -2048) || (s > 2047);
      end
      3'd1: begin
        w = (((im >> 5) & 32'h7F) << 25) | (32'(b.rs2) << 20) | (32'(b.rs1) << 15)
          | (32'(b.f3) << 12) | ((im & 32'h1F) << 7) | 32'(b.opc);
        e = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25)
          | (32'(b.rs2) << 20) | (32'(b.rs1) << 15) | (32'(b.f3) << 12)
          | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | 32'(b.opc);
        e = (s < -4096) || (s > 4095) || ((im % 2) != 0);
      end
      3'd3: begin
        w = (im & 32'hFFFF_F000) | (32'(b.rd) << 7) | 32'(b.opc);
        e = (im % 4096) != 0;
      end
      3'd4: begin
        w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
          | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12)
          | (32'(b.rd) << 7) | 32'(b.opc);
        e = (s < -1048576) || (s > 1048575) || ((im % 2) != 0);
      end
      default: begin
        w = 32'h0000_0013;
        e = 1'b1;
      end
    endcase
    return {e, w};
  endfunction

  function automatic bundle_t mk(input logic [2:0] fmt, input logic [6:0] opc,
                                 input logic [2:0] f3, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [31:0] imm);
    bundle_t b;
    b.fmt = fmt; b.opc = opc; b.f3 = f3; b.f7 = 7'h5A;
    b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.imm = imm;
    return b;
  endfunction

  function automatic bundle_t rand_bundle();
    bundle_t     b;
    logic [31:0] r;
    b.fmt = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
    b.opc = 7'($urandom); b.f3 = 3'($urandom); b.f7 = 7'($urandom);
    b.rd = 5'($urandom); b.rs1 = 5'($urandom); b.rs2 = 5'($urandom);
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       b.imm = r;
      1:       b.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      2:       b.imm = {{11{r[20]}}, r[20:1], 1'b0};
      default: b.imm = {r[31:12], 12'd0};
    endcase
    return b;
  endfunction

  // One clock: drive at negedge, check 1ns later, advance the model at posedge.
  task automatic step(input logic v, input bundle_t b, input logic ordy, output logic acc);
    logic        pop, wr_ok, push, exp_rdy;
    logic [32:0] e;
    @(negedge clk);
    in_valid = v; b_drv = b; out_ready = ordy;
    #1;
    pop     = (m_fifo > 0) && ordy;
    wr_ok   = (m_fifo < 2) || pop;
    push    = m_s1 && wr_ok;
    exp_rdy = !m_s1 || wr_ok;
    acc     = v && exp_rdy;
    e       = 33'd0;
    chk("in_ready", 32'(a_in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(a_out_valid), 32'(m_fifo > 0));
    chk("out_valid_b", 32'(b_out_valid), 32'(m_fifo > 0));
    chk("err_seen", 32'(a_err_seen), 32'(m_err_seen));
    if (pop) begin
      e = ref_enc(q[0]);
      chk("out_instr", a_out_instr, e[31:0]);
      chk("out_err", 32'(a_out_err), 32'(e[32]));
      chk("out_addr", a_out_addr, 32'(n_pop * 4));
      chk("out_instr_b", b_out_instr, e[31:0]);
      chk("out_addr_b", b_out_addr, BASE_B + 32'(n_pop * 4));
      pops.push_back({a_out_instr, a_out_addr, a_out_err});
      pop_addr_b.push_back(b_out_addr);
    end
    @(posedge clk);
    if (pop) begin
      void'(q.pop_front());
      m_err_seen = m_err_seen | e[32];
      n_pop++;
    end
    if (acc) q.push_back(b);
    m_fifo = m_fifo + (push ? 1 : 0) - (pop ? 1 : 0);
    if (acc) m_s1 = 1'b1;
    else if (push) m_s1 = 1'b0;
  endtask

  task automatic send(input bundle_t b, input logic ordy);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) step(1'b1, b, ordy, acc);
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, rand_bundle(), ordy, acc);
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 50 && q.size() > 0; i++) step(1'b0, rand_bundle(), 1'b1, acc);
    if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_s1 = 1'b0; m_fifo = 0; q.delete(); n_pop = 0; m_err_seen = 1'b0;
    pops.delete(); pop_addr_b.delete();
    #1;
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_instr", a_out_instr, 32'd0);
    chk("rst_out_addr", a_out_addr, 32'd0);
    chk("rst_out_addr_b", b_out_addr, BASE_B);
    chk("rst_out_err", 32'(a_out_err), 32'd0);
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_err_seen", 32'(a_err_seen), 32'd0);
  endtask

  initial begin
    int   accepts;
    logic acc;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; b_drv = '0;
    m_s1 = 1'b0; m_fifo = 0; n_pop = 0; m_err_seen = 1'b0;
    do_reset();

    // Single I-type word
    send(mk(3'd0, 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5), 1'b1);
    drain();
    chk("i_count", 32'(pops.size()), 32'd1);
    if (pops.size() >= 1) begin
      chk("i_instr", pops[0].instr, 32'h0050_0093);
      chk("i_addr", pops[0].addr, 32'd0);
      chk("i_err", 32'(pops[0].err), 32'd0);
    end

    // S then B back-to-back
    do_reset();
    send(mk(3'd1, 7'b0100011, 3'd2, 5'd0, 5'd1, 5'd2, 32'd8), 1'b1);
    send(mk(3'd2, 7'b1100011, 3'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC), 1'b1);
    drain();
    chk("sb_count", 32'(pops.size()), 32'd2);
    if (pops.size() >= 2) begin
      chk("sw_instr", pops[0].instr, 32'h0020_A423);
      chk("sw_addr", pops[0].addr, 32'd0);
      chk("beq_instr", pops[1].instr, 32'hFE00_0EE3);
      chk("beq_addr", pops[1].addr, 32'd4);
    end

    // Error cases and sticky err_seen
    do_reset();
    send(mk(3'd2, 7'b1100011, 3'd0, 5'd0, 5'd0, 5'd0, 32'd3), 1'b1);
    drain();
    @(negedge clk); #1;
    chk("b_err_seen", 32'(a_err_seen), 32'd1);
    send(mk(3'd6, 7'b0110011, 3'd1, 5'd3, 5'd4, 5'd5, 32'd0), 1'b1);
    send(mk(3'd4, 7'b1101111, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800), 1'b1);
    drain();
    chk("err_count", 32'(pops.size()), 32'd3);
    if (pops.size() >= 3) begin
      chk("b_odd_err", 32'(pops[0].err), 32'd1);
      chk("illegal_instr", pops[1].instr, 32'h0000_0013);
      chk("illegal_err", 32'(pops[1].err), 32'd1);
      chk("jal_instr", pops[2].instr, 32'h0010_00EF);
      chk("jal_err", 32'(pops[2].err), 32'd0);
    end

    // Backpressure: exactly three bundles fit (S1 + two FIFO entries)
    do_reset();
    accepts = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, rand_bundle(), 1'b0, acc);
      if (acc) accepts++;
    end
    chk("bp_accepts", 32'(accepts), 32'd3);
    @(negedge clk); #1;
    chk("bp_in_ready", 32'(a_in_ready), 32'd0);
    drain();
    chk("bp_count", 32'(pops.size()), 32'd3);
    if (pops.size() >= 3) begin
      chk("bp_addr0", pops[0].addr, 32'd0);
      chk("bp_addr1", pops[1].addr, 32'd4);
      chk("bp_addr2", pops[2].addr, 32'd8);
    end

    // Reset with two words queued
    do_reset();
    send(rand_bundle(), 1'b0);
    send(rand_bundle(), 1'b0);
    idle(2, 1'b0);
    chk("mid_queued", 32'(a_out_valid), 32'd1);
    do_reset();
    idle(3, 1'b1);
    send(mk(3'd0, 7'b0010011, 3'd0, 5'd2, 5'd3, 5'd0, 32'd7), 1'b1);
    drain();
    chk("mid_count", 32'(pops.size()), 32'd1);
    if (pops.size() >= 1) chk("mid_addr", pops[0].addr, 32'd0);

    // Address wrap on the high-base instance
    do_reset();
    send(mk(3'd0, 7'b0010011, 3'd0, 5'd1, 5'd0, 5'd0, 32'd1), 1'b1);
    send(mk(3'd0, 7'b0010011, 3'd0, 5'd2, 5'd0, 5'd0, 32'd2), 1'b1);
    drain();
    chk("wrap_count", 32'(pop_addr_b.size()), 32'd2);
    if (pop_addr_b.size() >= 2) begin
      chk("wrap_addr0", pop_addr_b[0], 32'hFFFF_FFFC);
      chk("wrap_addr1", pop_addr_b[1], 32'h0000_0000);
    end
    chk("wrap_err_seen", 32'(b_err_seen), 32'd0);

    // Random traffic with random backpressure
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), rand_bundle(), 1'($urandom_range(0, 3) != 0), acc);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
